// File: rtl/gauss_pkg.sv
// Shared defaults, counter widths and FSM encoding for the Gaussian filter pipeline controller.
package gauss_pkg;
  localparam int DEF_IMG_W = 400;
  localparam int DEF_IMG_H = 300;
  localparam int DEF_LAT   = 2 * DEF_IMG_W + 2;

  localparam int COL_W = 9;
  localparam int ROW_W = 9;
  localparam int ADV_W = 17;
  localparam int PIX_W = 17;
  localparam int DAT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;
endpackage

// File: rtl/raster_counter.sv
// Column/row raster position of the filter output; column wraps at W-1, row wraps at H-1.
module raster_counter
  import gauss_pkg::*;
#(
  parameter int W  = DEF_IMG_W,
  parameter int H  = DEF_IMG_H,
  parameter int CW = COL_W,
  parameter int RW = ROW_W
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_last
);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_end;

  assign w_col_end = (r_col == CW'(W - 1));
  assign o_last    = w_col_end && (r_row == RW'(H - 1));
  assign o_col     = r_col;
  assign o_row     = r_row;

  always_ff @(posedge Clk) begin
    if (Reset || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= o_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end
endmodule

// File: rtl/gauss_pipe_ctrl.sv
// Frame controller for a line-buffered Gaussian filter: clears the filter, streams pixels with
// downstream backpressure, flushes the LAT-deep pipeline and tracks the output raster position.
module gauss_pipe_ctrl
  import gauss_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int LAT   = DEF_LAT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [DAT_W-1:0] in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic [DAT_W-1:0] filt_din,
  output logic             filt_clk_en,
  output logic             filt_reset,
  output logic             out_valid,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             busy,
  output logic             frame_done
);
  localparam int NPIX = IMG_W * IMG_H;

  state_t           r_state, w_state_nxt;
  logic [ADV_W-1:0] r_adv_cnt;
  logic [PIX_W-1:0] r_in_cnt;
  logic             r_frame_done;

  logic             w_lat_done;
  logic             w_in_ready, w_clk_en, w_out_valid;
  logic [DAT_W-1:0] w_din;
  logic             w_out_hs, w_last;

  assign w_lat_done = (r_adv_cnt >= ADV_W'(LAT));

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_clk_en    = 1'b0;
    w_out_valid = 1'b0;
    w_din       = '0;
    case (r_state)
      IDLE:  if (start) w_state_nxt = CLEAR;
      CLEAR: begin
        w_clk_en    = 1'b1;
        w_state_nxt = STREAM;
      end
      STREAM: begin
        // Until the pipeline is primed, pixels are taken regardless of downstream.
        w_out_valid = in_valid && w_lat_done;
        w_in_ready  = !w_lat_done || out_ready;
        w_clk_en    = in_valid && w_in_ready;
        w_din       = in_data;
        if (w_clk_en && (r_in_cnt == PIX_W'(NPIX - 1))) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        w_out_valid = w_lat_done;
        w_clk_en    = out_ready;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_out_valid && out_ready && w_last) w_state_nxt = IDLE;
  end

  assign in_ready    = w_in_ready && !Reset;
  assign filt_clk_en = w_clk_en && !Reset;
  assign out_valid   = w_out_valid && !Reset;
  assign filt_reset  = Reset || (r_state == CLEAR);
  assign filt_din    = w_din;
  assign busy        = (r_state != IDLE);
  assign frame_done  = r_frame_done;
  assign w_out_hs    = out_valid && out_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_adv_cnt    <= '0;
      r_in_cnt     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_out_hs && w_last;
      if (r_state == CLEAR) begin
        r_adv_cnt <= '0;
        r_in_cnt  <= '0;
      end else begin
        if (filt_clk_en) r_adv_cnt <= r_adv_cnt + ADV_W'(1);
        if (filt_clk_en && (r_state == STREAM)) r_in_cnt <= r_in_cnt + PIX_W'(1);
      end
    end
  end

  raster_counter #(
    .W (IMG_W),
    .H (IMG_H),
    .CW(COL_W),
    .RW(ROW_W)
  ) u_raster (
    .Clk   (Clk),
    .Reset (Reset),
    .i_clr (r_state == CLEAR),
    .i_en  (w_out_hs),
    .o_col (out_col),
    .o_row (out_row),
    .o_last(w_last)
  );
endmodule

// File: tb/tb_gauss_pipe_ctrl.sv
// Directed and table-driven checks of gauss_pipe_ctrl at IMG_W=4, IMG_H=3, LAT=10.
module tb_gauss_pipe_ctrl;
  localparam int W = 4;
  localparam int H = 3;
  localparam int L = 10;
  localparam int N = W * H;

  logic       Clk, Reset, start, in_valid, in_ready, out_ready;
  logic [7:0] in_data, filt_din;
  logic       filt_clk_en, filt_reset, out_valid, busy, frame_done;
  logic [8:0] out_col, out_row;

  int checks = 0;
  int errors = 0;

  gauss_pipe_ctrl #(.IMG_W(W), .IMG_H(H), .LAT(L)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .filt_din   (filt_din),
    .filt_clk_en(filt_clk_en),
    .filt_reset (filt_reset),
    .out_valid  (out_valid),
    .out_col    (out_col),
    .out_row    (out_row),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic       st, iv, ordy;
    logic [7:0] din;
    logic       e_rdy, e_cen, e_frst, e_ov;
    int         e_col, e_row;   // -1: not checked
    logic       e_busy, e_done;
    logic [7:0] e_din;
  } vec_t;

  function automatic vec_t mk(input logic st, iv, ordy, input logic [7:0] din,
                              input logic rdy, cen, frst, ov, input int col, row,
                              input logic bsy, dn, input logic [7:0] edin);
    vec_t v;
    v.st = st; v.iv = iv; v.ordy = ordy; v.din = din;
    v.e_rdy = rdy; v.e_cen = cen; v.e_frst = frst; v.e_ov = ov;
    v.e_col = col; v.e_row = row; v.e_busy = bsy; v.e_done = dn; v.e_din = edin;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // One frame with stimulus selected by mode; checks handshake order, stalls and totals.
  // mode 0: always valid/ready, 1: 5-cycle downstream stall, 2: input gaps, 3: random.
  task automatic run_frame(input int mode, input string tag);
    int acc = 0, hs = 0, adv = 0, dones = 0, stall_left = 0, post = 0;
    bit stalled_once = 0, prev_stall = 0, streaming;
    logic [8:0] prev_col = '0, prev_row = '0;
    for (int c = 0; c < 1000; c++) begin
      start   = (c == 0);
      in_data = 8'(c + 8'h40);
      case (mode)
        1: begin
          in_valid = 1'b1;
          if (stall_left == 0 && !stalled_once && acc == 11) begin
            stall_left   = 5;
            stalled_once = 1;
          end
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        2: begin
          in_valid  = (c % 3 != 1);
          out_ready = 1'b1;
        end
        3: begin
          in_valid  = 1'($urandom_range(0, 1));
          out_ready = 1'($urandom_range(0, 1));
        end
        default: begin
          in_valid  = 1'b1;
          out_ready = 1'b1;
        end
      endcase
      @(negedge Clk);
      streaming = busy && !filt_reset && (acc < N);
      if (streaming && acc < L) begin
        chk({tag, " cen_mirrors_valid"}, filt_clk_en, in_valid);
        chk({tag, " early_out_valid"}, out_valid, 1'b0);
        chk({tag, " early_in_ready"}, in_ready, 1'b1);
      end
      if (out_valid && !out_ready) begin
        chk({tag, " stall_cen"}, filt_clk_en, 1'b0);
        chk({tag, " stall_in_ready"}, in_ready, 1'b0);
      end
      if (prev_stall) begin
        chk({tag, " held_col"}, out_col, prev_col);
        chk({tag, " held_row"}, out_row, prev_row);
      end
      if (out_valid && out_ready) begin
        chk({tag, " hs_col"}, out_col, hs % W);
        chk({tag, " hs_row"}, out_row, hs / W);
        hs++;
      end
      if (filt_clk_en && !filt_reset) adv++;
      if (streaming && in_valid && in_ready) acc++;
      if (frame_done) begin
        dones++;
        chk({tag, " done_after_last"}, hs, N);
      end
      prev_stall = out_valid && !out_ready;
      prev_col   = out_col;
      prev_row   = out_row;
      if (dones > 0) post++;
      next_cycle();
      if (post == 3) break;
    end
    start = 1'b0;
    chk({tag, " handshakes"}, hs, N);
    chk({tag, " advances"}, adv, N + L);
    chk({tag, " frame_done_count"}, dones, 1);
    chk({tag, " idle_after"}, busy, 1'b0);
  endtask

  vec_t tbl[26];

  initial begin
    // Full frame with valid/ready held high; a start during STREAM must be ignored.
    tbl[0] = mk(1, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    tbl[1] = mk(0, 1, 1, 8'h00, 0, 1, 1, 0, 0, 0, 1, 0, 8'h00);
    tbl[2]  = mk(0, 1, 1, 8'h11, 1, 1, 0, 0, 0, 0, 1, 0, 8'h11);
    tbl[3]  = mk(0, 1, 1, 8'h12, 1, 1, 0, 0, 0, 0, 1, 0, 8'h12);
    tbl[4]  = mk(0, 1, 1, 8'h13, 1, 1, 0, 0, 0, 0, 1, 0, 8'h13);
    tbl[5]  = mk(0, 1, 1, 8'h14, 1, 1, 0, 0, 0, 0, 1, 0, 8'h14);
    tbl[6]  = mk(1, 1, 1, 8'h15, 1, 1, 0, 0, 0, 0, 1, 0, 8'h15);
    tbl[7]  = mk(0, 1, 1, 8'h16, 1, 1, 0, 0, 0, 0, 1, 0, 8'h16);
    tbl[8]  = mk(0, 1, 1, 8'h17, 1, 1, 0, 0, 0, 0, 1, 0, 8'h17);
    tbl[9]  = mk(0, 1, 1, 8'h18, 1, 1, 0, 0, 0, 0, 1, 0, 8'h18);
    tbl[10] = mk(0, 1, 1, 8'h19, 1, 1, 0, 0, 0, 0, 1, 0, 8'h19);
    tbl[11] = mk(0, 1, 1, 8'h1A, 1, 1, 0, 0, 0, 0, 1, 0, 8'h1A);
    tbl[12] = mk(0, 1, 1, 8'h1B, 1, 1, 0, 1, 0, 0, 1, 0, 8'h1B);
    tbl[13] = mk(0, 1, 1, 8'h1C, 1, 1, 0, 1, 1, 0, 1, 0, 8'h1C);
    tbl[14] = mk(0, 1, 1, 8'hEE, 0, 1, 0, 1, 2, 0, 1, 0, 8'h00);
    tbl[15] = mk(0, 1, 1, 8'hEE, 0, 1, 0, 1, 3, 0, 1, 0, 8'h00);
    tbl[16] = mk(0, 1, 1, 8'hEE, 0, 1, 0, 1, 0, 1, 1, 0, 8'h00);
    tbl[17] = mk(0, 1, 1, 8'hEE, 0, 1, 0, 1, 1, 1, 1, 0, 8'h00);
    tbl[18] = mk(0, 1, 1, 8'hEE, 0, 1, 0, 1, 2, 1, 1, 0, 8'h00);
    tbl[19] = mk(0, 1, 1, 8'hEE, 0, 1, 0, 1, 3, 1, 1, 0, 8'h00);
    tbl[20] = mk(0, 1, 1, 8'hEE, 0, 1, 0, 1, 0, 2, 1, 0, 8'h00);
    tbl[21] = mk(0, 1, 1, 8'hEE, 0, 1, 0, 1, 1, 2, 1, 0, 8'h00);
    tbl[22] = mk(0, 1, 1, 8'hEE, 0, 1, 0, 1, 2, 2, 1, 0, 8'h00);
    tbl[23] = mk(0, 1, 1, 8'hEE, 0, 1, 0, 1, 3, 2, 1, 0, 8'h00);
    tbl[24] = mk(0, 1, 1, 8'h00, 0, 0, 0, 0, -1, -1, 0, 1, 8'h00);
    tbl[25] = mk(0, 1, 1, 8'h00, 0, 0, 0, 0, -1, -1, 0, 0, 8'h00);

    Reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("rst busy", busy, 1'b0);
    chk("rst filt_reset", filt_reset, 1'b1);
    chk("rst filt_clk_en", filt_clk_en, 1'b0);
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst frame_done", frame_done, 1'b0);
    start = 1'b0;
    next_cycle();
    Reset = 1'b0;
    @(negedge Clk);
    chk("idle filt_reset", filt_reset, 1'b0);
    chk("idle col", out_col, 0);
    next_cycle();

    begin
      int adv = 0, hs = 0;
      for (int i = 0; i < 26; i++) begin
        start = tbl[i].st; in_valid = tbl[i].iv; out_ready = tbl[i].ordy; in_data = tbl[i].din;
        @(negedge Clk);
        chk($sformatf("tbl[%0d] in_ready", i), in_ready, tbl[i].e_rdy);
        chk($sformatf("tbl[%0d] filt_clk_en", i), filt_clk_en, tbl[i].e_cen);
        chk($sformatf("tbl[%0d] filt_reset", i), filt_reset, tbl[i].e_frst);
        chk($sformatf("tbl[%0d] out_valid", i), out_valid, tbl[i].e_ov);
        chk($sformatf("tbl[%0d] busy", i), busy, tbl[i].e_busy);
        chk($sformatf("tbl[%0d] frame_done", i), frame_done, tbl[i].e_done);
        chk($sformatf("tbl[%0d] filt_din", i), filt_din, tbl[i].e_din);
        if (tbl[i].e_col >= 0) begin
          chk($sformatf("tbl[%0d] out_col", i), out_col, tbl[i].e_col);
          chk($sformatf("tbl[%0d] out_row", i), out_row, tbl[i].e_row);
        end
        if (filt_clk_en && !filt_reset) adv++;
        if (out_valid && out_ready) hs++;
        next_cycle();
      end
      chk("tbl advances", adv, N + L);
      chk("tbl handshakes", hs, N);
    end

    run_frame(1, "stall");
    run_frame(2, "gaps");
    run_frame(3, "random");

    // Reset in the middle of FLUSH, then a clean frame.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      start = (c == 0);
      next_cycle();
    end
    start = 1'b0;
    @(negedge Clk);
    chk("flush busy", busy, 1'b1);
    chk("flush in_ready", in_ready, 1'b0);
    chk("flush out_valid", out_valid, 1'b1);
    next_cycle();
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_in_flush filt_reset", filt_reset, 1'b1);
    chk("rst_in_flush filt_clk_en", filt_clk_en, 1'b0);
    chk("rst_in_flush in_ready", in_ready, 1'b0);
    next_cycle();
    Reset = 1'b0;
    @(negedge Clk);
    chk("after_rst busy", busy, 1'b0);
    chk("after_rst frame_done", frame_done, 1'b0);
    chk("after_rst out_col", out_col, 0);
    chk("after_rst out_row", out_row, 0);
    chk("after_rst out_valid", out_valid, 1'b0);
    next_cycle();
    run_frame(0, "restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
